// File: rtl/hazard_freeze_controller_pkg.sv
// hazard_freeze_controller_pkg: shared pipeline types and defaults for the freeze controller
package hazard_freeze_controller_pkg;

   localparam int MAX_WAIT_DEF = 64;
   localparam int CNT_W_DEF    = 16;
   localparam int REG_W        = 4;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags an ID-stage read of a register whose value cannot yet be supplied
module hazard_detect
   import hazard_freeze_controller_pkg::*;
(
   input  logic [REG_W-1:0] src1_i,
   input  logic [REG_W-1:0] src2_i,
   input  logic             two_src_i,
   input  logic [REG_W-1:0] Dest_ER_i,
   input  logic [REG_W-1:0] Dest_MR_i,
   input  logic             WB_EN_ER_i,
   input  logic             WB_EN_MR_i,
   input  logic             MEM_R_EN_ER_i,
   input  logic             fwd_en_i,
   output logic             hazard_o
);

   logic m1, m2;

   // with forwarding only a load in EX stalls; without it any pending EX or MEM write does
   always_comb begin
      m1 = fwd_en_i ? (WB_EN_ER_i & MEM_R_EN_ER_i & (src1_i == Dest_ER_i))
                    : ((WB_EN_ER_i & (src1_i == Dest_ER_i)) | (WB_EN_MR_i & (src1_i == Dest_MR_i)));
      m2 = fwd_en_i ? (WB_EN_ER_i & MEM_R_EN_ER_i & (src2_i == Dest_ER_i))
                    : ((WB_EN_ER_i & (src2_i == Dest_ER_i)) | (WB_EN_MR_i & (src2_i == Dest_MR_i)));
      hazard_o = m1 | (two_src_i & m2);
   end

endmodule

// File: rtl/hazard_freeze_controller.sv
// hazard_freeze_controller: pipeline freeze/bubble/flush control with memory-wait tracking and perf counters
module hazard_freeze_controller
   import hazard_freeze_controller_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1_i,
   input  logic [REG_W-1:0] src2_i,
   input  logic             two_src_i,
   input  logic [REG_W-1:0] Dest_ER_i,
   input  logic [REG_W-1:0] Dest_MR_i,
   input  logic             WB_EN_ER_i,
   input  logic             WB_EN_MR_i,
   input  logic             MEM_R_EN_ER_i,
   input  logic             fwd_en_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             freeze_pc_o,
   output logic             freeze_ifid_o,
   output logic             freeze_idex_o,
   output logic             freeze_exmem_o,
   output logic             bubble_idex_o,
   output logic             flush_ifid_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   fsm_state_e       state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic             mem_freeze, hazard;

   hazard_detect u_hazard_detect (
      .src1_i        (src1_i),
      .src2_i        (src2_i),
      .two_src_i     (two_src_i),
      .Dest_ER_i     (Dest_ER_i),
      .Dest_MR_i     (Dest_MR_i),
      .WB_EN_ER_i    (WB_EN_ER_i),
      .WB_EN_MR_i    (WB_EN_MR_i),
      .MEM_R_EN_ER_i (MEM_R_EN_ER_i),
      .fwd_en_i      (fwd_en_i),
      .hazard_o      (hazard)
   );

   // a memory stall holds everything; a taken branch beats a hazard; a branch seen while
   // frozen stays on the input because EX is held, so it flushes on the first unfrozen cycle
   always_comb begin
      mem_freeze     = mem_req_i & ~mem_ready_i;
      freeze_pc_o    = mem_freeze | (hazard & ~branch_taken_i);
      freeze_ifid_o  = mem_freeze | (hazard & ~branch_taken_i);
      freeze_idex_o  = mem_freeze;
      freeze_exmem_o = mem_freeze;
      bubble_idex_o  = ~mem_freeze & (hazard | branch_taken_i);
      flush_ifid_o   = ~mem_freeze & branch_taken_i;
   end

   // memory-wait FSM, saturating wait counter, sticky timeout and saturating perf counters
   always_comb begin
      state_d   = (state_q == RUN) ? (mem_freeze ? MEM_WAIT : RUN) : (mem_ready_i ? RUN : MEM_WAIT);
      wait_d    = (state_q == RUN) ? '0 : ((wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1);
      timeout_d = timeout_q | ((state_q == MEM_WAIT) && (wait_d == WW'(MAX_WAIT)));
      stall_d   = (freeze_pc_o && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
      flush_d   = (flush_ifid_o && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign mem_timeout_o  = timeout_q;
   assign stall_cycles_o = stall_q;
   assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_hazard_freeze_controller.sv
// tb_hazard_freeze_controller: directed and randomized checks against a behavioural model
module tb_hazard_freeze_controller;

   localparam int MW  = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    src1, src2, dest_er, dest_mr;
   logic          two_src, wb_er, wb_mr, memr_er, fwd_en, branch, mem_req, mem_ready;
   logic          fpc, fif, fidex, fexm, bub, fl, tmo;
   logic [CW-1:0] stall_cycles, flush_count;

   int tests = 0;
   int fails = 0;

   bit m_wait, m_tmo;
   int m_wcnt, m_stall, m_flush;
   bit e_fpc, e_fidex, e_bub, e_fl;

   always #5 clk = ~clk;

   hazard_freeze_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .src1_i         (src1),
      .src2_i         (src2),
      .two_src_i      (two_src),
      .Dest_ER_i      (dest_er),
      .Dest_MR_i      (dest_mr),
      .WB_EN_ER_i     (wb_er),
      .WB_EN_MR_i     (wb_mr),
      .MEM_R_EN_ER_i  (memr_er),
      .fwd_en_i       (fwd_en),
      .branch_taken_i (branch),
      .mem_req_i      (mem_req),
      .mem_ready_i    (mem_ready),
      .freeze_pc_o    (fpc),
      .freeze_ifid_o  (fif),
      .freeze_idex_o  (fidex),
      .freeze_exmem_o (fexm),
      .bubble_idex_o  (bub),
      .flush_ifid_o   (fl),
      .mem_timeout_o  (tmo),
      .stall_cycles_o (stall_cycles),
      .flush_count_o  (flush_count)
   );

   function automatic bit reads_pending(input logic [3:0] r);
      if (fwd_en) return wb_er && memr_er && (r == dest_er);
      return (wb_er && (r == dest_er)) || (wb_mr && (r == dest_mr));
   endfunction

   task automatic model_comb();
      bit mf, hz;
      mf = mem_req && !mem_ready;
      hz = reads_pending(src1) || (two_src && reads_pending(src2));
      e_fidex = mf;
      e_fl    = !mf && branch;
      e_bub   = !mf && (hz || branch);
      e_fpc   = mf || (hz && !branch);
   endtask

   task automatic model_edge();
      if (!rst) begin
         m_wait = 0; m_wcnt = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e_fpc && m_stall < SAT) m_stall++;
         if (e_fl && m_flush < SAT) m_flush++;
         if (m_wait) begin
            m_wcnt++;
            if (m_wcnt >= MW) m_tmo = 1;
            if (mem_ready) m_wait = 0;
         end else if (mem_req && !mem_ready) begin
            m_wait = 1;
            m_wcnt = 0;
         end
      end
   endtask

   task automatic tick();
      model_comb();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      src1 = 0; src2 = 0; dest_er = 0; dest_mr = 0; two_src = 0; wb_er = 0; wb_mr = 0;
      memr_er = 0; fwd_en = 0; branch = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic test_reset();
      idle();
      rst = 0;
      tick();
      tick();
      rst = 1;
      #1;
      tests++;
      if ({stall_cycles, flush_count, tmo} !== 9'b0) begin
         fails++;
         $display("FAIL reset_regs: got %h/%h/%b want 0/0/0", stall_cycles, flush_count, tmo);
      end
      tests++;
      if ({fpc, fif, fidex, fexm, bub, fl} !== 6'b0) begin
         fails++;
         $display("FAIL reset_idle_outputs: got %b want 000000", {fpc, fif, fidex, fexm, bub, fl});
      end
   endtask

   typedef struct packed {
      bit fwd; bit memr; bit wber; bit wbmr; bit two;
      logic [3:0] s1; logic [3:0] s2; logic [3:0] de; logic [3:0] dm;
      bit exp;
   } hv_t;

   task automatic test_hazard();
      hv_t hv[7];
      hv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd3, 4'd0, 1'b1};
      hv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd3, 4'd0, 1'b0};
      hv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd3, 4'd0, 1'b1};
      hv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 4'd3, 4'd5, 1'b0};
      hv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd5, 4'd3, 4'd5, 1'b1};
      hv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 4'd3, 4'd0, 1'b1};
      hv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd3, 4'd1, 1'b0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         idle();
         fwd_en = hv[i].fwd; memr_er = hv[i].memr; wb_er = hv[i].wber; wb_mr = hv[i].wbmr;
         two_src = hv[i].two; src1 = hv[i].s1; src2 = hv[i].s2; dest_er = hv[i].de; dest_mr = hv[i].dm;
         #1;
         tests++;
         if ({fpc, fif, fidex, fexm, bub, fl} !== {hv[i].exp, hv[i].exp, 2'b00, hv[i].exp, 1'b0}) begin
            fails++;
            $display("FAIL hazard_vec%0d: got %b want %b", i, {fpc, fif, fidex, fexm, bub, fl},
                     {hv[i].exp, hv[i].exp, 2'b00, hv[i].exp, 1'b0});
         end
         tick();
         tests++;
         if (stall_cycles !== CW'(m_stall)) begin
            fails++;
            $display("FAIL hazard_stall%0d: got %0d want %0d", i, stall_cycles, m_stall);
         end
      end
   endtask

   task automatic test_branch_override();
      do_reset();
      idle();
      fwd_en = 1; memr_er = 1; wb_er = 1; dest_er = 3; src1 = 3; branch = 1;
      #1;
      tests++;
      if ({fpc, fif, fidex, fexm, bub, fl} !== 6'b000011) begin
         fails++;
         $display("FAIL branch_override: got %b want 000011", {fpc, fif, fidex, fexm, bub, fl});
      end
      tick();
      tests++;
      if ({stall_cycles, flush_count} !== {CW'(0), CW'(1)}) begin
         fails++;
         $display("FAIL branch_counts: got %0d/%0d want 0/1", stall_cycles, flush_count);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      idle();
      for (int w = 0; w < 2; w++) begin
         mem_req = 1;
         mem_ready = 0;
         for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({fpc, fif, fidex, fexm, bub, fl} !== 6'b111100) begin
               fails++;
               $display("FAIL mem_freeze w%0d c%0d: got %b want 111100", w, i, {fpc, fif, fidex, fexm, bub, fl});
            end
            tick();
         end
         mem_ready = 1;
         #1;
         tests++;
         if ({fpc, fif, fidex, fexm} !== 4'b0000) begin
            fails++;
            $display("FAIL mem_ready_release w%0d: got %b want 0000", w, {fpc, fif, fidex, fexm});
         end
         tick();
         mem_req = 0;
         mem_ready = 0;
         tick();
         tests++;
         if ({tmo, stall_cycles} !== {m_tmo, CW'(m_stall)}) begin
            fails++;
            $display("FAIL mem_wait_after w%0d: got tmo=%b stall=%0d want tmo=%b stall=%0d", w, tmo, stall_cycles, m_tmo, m_stall);
         end
      end
   endtask

   task automatic test_deferred_branch();
      do_reset();
      idle();
      mem_req = 1;
      branch = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if ({bub, fl, fpc} !== 3'b001) begin
            fails++;
            $display("FAIL deferred_branch_held c%0d: got bub,fl,fpc=%b want 001", i, {bub, fl, fpc});
         end
         tick();
      end
      mem_ready = 1;
      #1;
      tests++;
      if ({bub, fl, fpc} !== 3'b110) begin
         fails++;
         $display("FAIL deferred_branch_fire: got bub,fl,fpc=%b want 110", {bub, fl, fpc});
      end
      tick();
      idle();
      tick();
      tests++;
      if (flush_count !== CW'(1)) begin
         fails++;
         $display("FAIL deferred_flush_count: got %0d want 1", flush_count);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      idle();
      mem_req = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (tmo !== m_tmo) begin
            fails++;
            $display("FAIL timeout_c%0d: got %b want %b", i, tmo, m_tmo);
         end
      end
      tests++;
      if ({tmo, fpc, fexm} !== 3'b111) begin
         fails++;
         $display("FAIL timeout_still_frozen: got tmo,fpc,fexm=%b want 111", {tmo, fpc, fexm});
      end
      mem_ready = 1;
      tick();
      idle();
      tick();
      tick();
      tests++;
      if (tmo !== 1'b1) begin
         fails++;
         $display("FAIL timeout_sticky: got %b want 1", tmo);
      end
      do_reset();
      #1;
      tests++;
      if (tmo !== 1'b0) begin
         fails++;
         $display("FAIL timeout_reset: got %b want 0", tmo);
      end
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      idle();
      fwd_en = 0; wb_er = 1; dest_er = 7; src1 = 7;
      for (int i = 0; i < 20; i++) begin
         tick();
         tests++;
         if (stall_cycles !== CW'(m_stall)) begin
            fails++;
            $display("FAIL stall_sat_c%0d: got %0d want %0d", i, stall_cycles, m_stall);
         end
      end
      tests++;
      if (stall_cycles !== CW'(15)) begin
         fails++;
         $display("FAIL stall_no_wrap: got %0d want 15", stall_cycles);
      end
      idle();
      mem_req = 1;
      tick();
      tick();
      tick();
      rst = 0;
      tick();
      rst = 1;
      #1;
      tests++;
      if ({stall_cycles, flush_count, tmo, fpc} !== {CW'(0), CW'(0), 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_mid_wait: got %0d/%0d/%b/%b want 0/0/0/1", stall_cycles, flush_count, tmo, fpc);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if ({tmo, stall_cycles} !== {m_tmo, CW'(m_stall)}) begin
            fails++;
            $display("FAIL rewait_c%0d: got tmo=%b stall=%0d want tmo=%b stall=%0d", i, tmo, stall_cycles, m_tmo, m_stall);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
         dest_er = 4'($urandom_range(0, 3)); dest_mr = 4'($urandom_range(0, 3));
         two_src = 1'($urandom); wb_er = 1'($urandom); wb_mr = 1'($urandom);
         memr_er = 1'($urandom); fwd_en = 1'($urandom);
         branch = ($urandom_range(0, 3) == 0);
         mem_req = 1'($urandom);
         mem_ready = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 60) != 0);
         #1;
         model_comb();
         tests++;
         if ({fpc, fif, fidex, fexm, bub, fl} !== {e_fpc, e_fpc, e_fidex, e_fidex, e_bub, e_fl}) begin
            fails++;
            $display("FAIL rand_comb_c%0d: got %b want %b", i, {fpc, fif, fidex, fexm, bub, fl},
                     {e_fpc, e_fpc, e_fidex, e_fidex, e_bub, e_fl});
         end
         tick();
         tests++;
         if ({tmo, stall_cycles, flush_count} !== {m_tmo, CW'(m_stall), CW'(m_flush)}) begin
            fails++;
            $display("FAIL rand_regs_c%0d: got %b/%0d/%0d want %b/%0d/%0d", i, tmo, stall_cycles, flush_count,
                     m_tmo, m_stall, m_flush);
         end
      end
      rst = 1;
   endtask

   initial begin
      test_reset();
      test_hazard();
      test_branch_override();
      test_mem_wait();
      test_deferred_branch();
      test_timeout();
      test_saturation_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_freeze_controller.md
HAZARD_FREEZE_CONTROLLER -- requirements
Module: hazard_freeze_controller

Interface
REQ-001 Parameter MAX_WAIT, default 64: memory-wait cycle limit before the timeout flag sets.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 src1, src2  in  4 each  ID-stage source register numbers.
REQ-006 two_src  in  1  ID instruction reads src2.
REQ-007 Dest_ER, Dest_MR  in  4 each  destination register in ID/EX and EX/MEM registers.
REQ-008 WB_EN_ER, WB_EN_MR  in  1 each  writeback enable for those stages.
REQ-009 MEM_R_EN_ER  in  1  ID/EX instruction is a load.
REQ-010 fwd_en  in  1  forwarding unit active.
REQ-011 branch_taken  in  1  EX-stage branch resolved taken.
REQ-012 mem_req  in  1  MEM stage issues a cache/SRAM read or write.
REQ-013 mem_ready  in  1  cache/SRAM completes the access this cycle.
REQ-014 freeze_pc, freeze_ifid, freeze_idex, freeze_exmem  out  1 each  hold the named register.
REQ-015 bubble_idex  out  1  load NOP into ID/EX.
REQ-016 flush_ifid  out  1  load NOP into IF/ID.
REQ-017 mem_timeout  out  1  sticky wait-limit flag.
REQ-018 stall_cycles, flush_count  out  CNT_W each  saturating performance counters.

Function
REQ-019 The FSM SHALL have states RUN and MEM_WAIT.
REQ-020 RUN->MEM_WAIT when mem_req=1 and mem_ready=0; MEM_WAIT->RUN on the cycle after mem_ready=1; mem_req=1 with mem_ready=1 in RUN stays in RUN.
REQ-021 mem_freeze = mem_req & ~mem_ready (combinational, zero latency) SHALL assert all four freeze outputs; bubble_idex and flush_ifid SHALL be 0 while mem_freeze=1.
REQ-022 A hazard SHALL be flagged when (src1 matches) or (two_src and src2 matches).
REQ-023 With fwd_en=1, a match is against Dest_ER with WB_EN_ER=1 and MEM_R_EN_ER=1.
REQ-024 With fwd_en=0, a match is against Dest_ER with WB_EN_ER=1, or against Dest_MR with WB_EN_MR=1.
REQ-025 A hazard SHALL assert freeze_pc, freeze_ifid and bubble_idex for one cycle per hazard cycle, with freeze_idex=0 and freeze_exmem=0.
REQ-026 branch_taken without mem_freeze SHALL assert flush_ifid and bubble_idex, and SHALL override a simultaneous hazard (freeze_pc=freeze_ifid=0).
REQ-027 branch_taken during mem_freeze SHALL be deferred; the flush fires on the first unfrozen cycle, because EX is held.
REQ-028 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-029 When the wait counter reaches MAX_WAIT, mem_timeout SHALL set and remain set until reset; freezing SHALL continue.
REQ-030 stall_cycles SHALL increment on every cycle with freeze_pc=1; flush_count SHALL increment on every cycle with flush_ifid=1.
REQ-031 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 Outputs other than the counters and mem_timeout SHALL be combinational from inputs; there is no added latency.

Reset
REQ-033 rst=0 at a clock edge SHALL force state RUN, wait counter 0, mem_timeout 0, stall_cycles 0 and flush_count 0.
REQ-034 Reset mid-MEM_WAIT SHALL abandon the wait; combinational freezes still follow the inputs after reset.

Structure
REQ-035 The state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the MAX_WAIT and CNT_W defaults SHALL live in the shared pipeline package.
REQ-036 The hazard-compare logic SHALL be one sub-module, hazard_detect.
REQ-037 The FSM, wait counter and perf counters SHALL live in the top module.

Verification
REQ-038 fwd_en=1, MEM_R_EN_ER=1, WB_EN_ER=1, Dest_ER=3, src1=3 -> freeze_pc=freeze_ifid=bubble_idex=1 for that cycle; stall_cycles +1.
REQ-039 fwd_en=1, MEM_R_EN_ER=0, same registers -> no freeze; fwd_en=0 -> freeze asserted; src2=Dest_MR=5, two_src=0 -> no freeze.
REQ-040 mem_req=1 and mem_ready=0 for 3 cycles, then 1 -> all freezes high for 3 cycles; state MEM_WAIT; RUN one cycle after ready.
REQ-041 branch_taken=1 during mem_freeze -> flush_ifid=0 until mem_ready; flush_ifid=1 on the first unfrozen cycle; flush_count=1.
REQ-042 MAX_WAIT=4, mem_ready held 0 for 10 cycles -> mem_timeout=1 from cycle 4 and stays 1 after ready; cleared only by rst=0.
REQ-043 CNT_W=4, 20 hazard cycles -> stall_cycles=15 with no wrap; rst=0 mid-MEM_WAIT -> counters 0, state RUN next cycle.
